// File: rtl/cpkt_wrr_sched.sv
// cpkt_wrr_sched - weighted round-robin cell scheduler for the TCP RX cell FIFOs.
// Grants one eligible queue per cell slot, reads a fixed CELL_LEN-beat cell from it,
// and emits cell framing aligned with the FIFO read data (FIFO read latency 1).
// Optional rate limiting (GAP state) is built only when the macro
// CPKT_WRR_SCHED_RATE_LIMIT_EN is defined.
module cpkt_wrr_sched #(
   parameter int QUE_NUM  = 8,
   parameter int SEL_WID  = 3,
   parameter int CELL_LEN = 4,
   parameter int WGT_WID  = 4,
   parameter int CELL_GAP = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WGT_WID*QUE_NUM-1:0] cfg_wgt,
   input  logic                       cfg_limit_en,
   input  logic [QUE_NUM-1:0]         que_nempty,
   input  logic                       out_rdy,
   output logic [QUE_NUM-1:0]         que_ren,
   output logic                       cell_vld,
   output logic                       cell_sop,
   output logic                       cell_eop,
   output logic [SEL_WID-1:0]         cell_qid,
   output logic                       sched_busy
);

   localparam int                  BEAT_WID  = (CELL_LEN > 2) ? $clog2(CELL_LEN) : 1;
   localparam logic [BEAT_WID-1:0] BEAT_LAST = BEAT_WID'(CELL_LEN - 1);

`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
   localparam int                  GAP_WID   = $clog2(CELL_GAP + 1);
   localparam logic [GAP_WID-1:0]  GAP_LAST  = GAP_WID'(CELL_GAP - 1);
   typedef enum logic [1:0] {ST_ARB = 2'd0, ST_READ = 2'd1, ST_GAP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_ARB = 2'd0, ST_READ = 2'd1} state_t;
`endif

   // scheduler state (que_ren stage)
   state_t               r_state;
   logic [SEL_WID-1:0]   r_cur_q;
   logic [WGT_WID-1:0]   r_cred;
   logic [BEAT_WID-1:0]  r_beat;
   logic [QUE_NUM-1:0]   r_ren_p0;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
   logic [GAP_WID-1:0]   r_gap_cnt;
   logic [GAP_WID-1:0]   w_gap_nxt;
`else
   logic                 w_unused_limit_en;
`endif

   // output framing stage, one cycle behind que_ren (aligned with FIFO rdata)
   logic                 r_vld_p1;
   logic                 r_sop_p1;
   logic                 r_eop_p1;
   logic [SEL_WID-1:0]   r_qid_p1;

   // next-state values
   state_t               w_state_nxt;
   logic [SEL_WID-1:0]   w_cur_q_nxt;
   logic [WGT_WID-1:0]   w_cred_nxt;
   logic [BEAT_WID-1:0]  w_beat_nxt;
   logic [QUE_NUM-1:0]   w_ren_nxt;

   // arbitration
   logic [WGT_WID-1:0]   w_wgt [QUE_NUM];
   logic [QUE_NUM-1:0]   w_elig;
   logic [SEL_WID-1:0]   w_idx;
   logic [SEL_WID-1:0]   w_sel_q;
   logic [WGT_WID-1:0]   w_cred_base;
   logic                 w_found;
   logic                 w_grant;
   logic [QUE_NUM-1:0]   w_sel_onehot;

`ifndef CPKT_WRR_SCHED_RATE_LIMIT_EN
   // Rate limiting is not built; the enable input has no effect.
   assign w_unused_limit_en = cfg_limit_en;
`endif

   // Unpack weights and mark queues that hold a cell and are enabled.
   always_comb begin
      w_elig = '0;
      for (int q = 0; q < QUE_NUM; q++) begin
         w_wgt[q]  = cfg_wgt[q*WGT_WID +: WGT_WID];
         w_elig[q] = que_nempty[q] && (w_wgt[q] != '0);
      end
   end

   // Pick the queue for the next cell: keep the current one while it has credit,
   // otherwise take the first eligible queue after it (itself last) and reload credit.
   always_comb begin
      w_found     = 1'b0;
      w_sel_q     = r_cur_q;
      w_cred_base = r_cred;
      w_idx       = r_cur_q;
      if (w_elig[r_cur_q] && (r_cred != '0)) begin
         w_found = 1'b1;
      end else begin
         for (int k = 1; k <= QUE_NUM; k++) begin
            w_idx = r_cur_q + SEL_WID'(k);
            if (!w_found && w_elig[w_idx]) begin
               w_found     = 1'b1;
               w_sel_q     = w_idx;
               w_cred_base = w_wgt[w_idx];
            end
         end
      end
   end

   assign w_grant      = out_rdy && w_found;
   assign w_sel_onehot = {{(QUE_NUM-1){1'b0}}, 1'b1} << w_sel_q;

   // Next-state and next read-enable decode for ARB / READ / GAP.
   always_comb begin
      w_state_nxt = r_state;
      w_cur_q_nxt = r_cur_q;
      w_cred_nxt  = r_cred;
      w_beat_nxt  = r_beat;
      w_ren_nxt   = r_ren_p0;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
      w_gap_nxt   = r_gap_cnt;
`endif
      case (r_state)
         ST_ARB: begin
            w_ren_nxt = '0;
            if (w_grant) begin
               w_state_nxt = ST_READ;
               w_cur_q_nxt = w_sel_q;
               w_cred_nxt  = w_cred_base - WGT_WID'(1);
               w_beat_nxt  = '0;
               w_ren_nxt   = w_sel_onehot;
            end
         end
         ST_READ: begin
            // A cell is never cut short: out_rdy and que_nempty are not looked at here.
            if (r_beat == BEAT_LAST) begin
               w_ren_nxt   = '0;
               w_beat_nxt  = '0;
               w_state_nxt = ST_ARB;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
               if (cfg_limit_en) begin
                  w_state_nxt = ST_GAP;
                  w_gap_nxt   = '0;
               end
`endif
            end else begin
               w_beat_nxt = r_beat + BEAT_WID'(1);
            end
         end
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
         ST_GAP: begin
            w_ren_nxt = '0;
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt = ST_ARB;
               w_gap_nxt   = '0;
            end else begin
               w_gap_nxt = r_gap_cnt + GAP_WID'(1);
            end
         end
`endif
         default: begin
            w_state_nxt = ST_ARB;
            w_ren_nxt   = '0;
            w_beat_nxt  = '0;
         end
      endcase
   end

   // Scheduler state register; que_ren is registered here so it drops on reset at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_ARB;
         r_cur_q   <= '0;
         r_cred    <= '0;
         r_beat    <= '0;
         r_ren_p0  <= '0;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
         r_gap_cnt <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_cur_q   <= w_cur_q_nxt;
         r_cred    <= w_cred_nxt;
         r_beat    <= w_beat_nxt;
         r_ren_p0  <= w_ren_nxt;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
         r_gap_cnt <= w_gap_nxt;
`endif
      end
   end

   // ---- stage p0 -> p1: delay framing by the FIFO read latency ----
   // Output framing register, one cycle behind the read enables.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_sop_p1 <= 1'b0;
         r_eop_p1 <= 1'b0;
         r_qid_p1 <= '0;
      end else begin
         r_vld_p1 <= |r_ren_p0;
         r_sop_p1 <= (|r_ren_p0) && (r_beat == '0);
         r_eop_p1 <= (|r_ren_p0) && (r_beat == BEAT_LAST);
         if (|r_ren_p0) begin
            r_qid_p1 <= r_cur_q;
         end
      end
   end

   assign que_ren    = r_ren_p0;
   assign cell_vld   = r_vld_p1;
   assign cell_sop   = r_sop_p1;
   assign cell_eop   = r_eop_p1;
   assign cell_qid   = r_qid_p1;
   assign sched_busy = (r_state != ST_ARB);

endmodule

// File: tb/tb_cpkt_wrr_sched.sv
// tb_cpkt_wrr_sched - directed bench for cpkt_wrr_sched with a cell-level
// reference model (a plan of upcoming read cycles) checked every cycle.
`timescale 1ns/1ps
module tb_cpkt_wrr_sched;
   localparam int QN = 8;
   localparam int SW = 3;
   localparam int CL = 4;
   localparam int WW = 4;
   localparam int CG = 12;
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
   localparam int LIM_SPACING = CL + 1 + CG;
`else
   localparam int LIM_SPACING = CL + 1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WW*QN-1:0]  cfg_wgt = '0;
   logic              cfg_limit_en = 1'b0;
   logic [QN-1:0]     que_nempty = '0;
   logic              out_rdy = 1'b0;
   logic [QN-1:0]     que_ren;
   logic              cell_vld, cell_sop, cell_eop;
   logic [SW-1:0]     cell_qid;
   logic              sched_busy;

   cpkt_wrr_sched #(.QUE_NUM(QN), .SEL_WID(SW), .CELL_LEN(CL), .WGT_WID(WW), .CELL_GAP(CG)) dut (
      .clk(clk), .rst(rst), .cfg_wgt(cfg_wgt), .cfg_limit_en(cfg_limit_en),
      .que_nempty(que_nempty), .out_rdy(out_rdy), .que_ren(que_ren),
      .cell_vld(cell_vld), .cell_sop(cell_sop), .cell_eop(cell_eop),
      .cell_qid(cell_qid), .sched_busy(sched_busy));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // m_cur describes the current cycle: -2 free (arbitrating), -1 idle gap,
   // otherwise q*256+beat for a read beat. m_plan holds the cycles already committed.
   int m_plan[$];
   int m_cur  = -2;
   int m_prev = -2;
   int m_ptr  = 0;
   int m_cred = 0;

   function automatic bit elig(input int q);
      return que_nempty[q] && (cfg_wgt[q*WW +: WW] != 0);
   endfunction

   function automatic bit limit_on();
`ifdef CPKT_WRR_SCHED_RATE_LIMIT_EN
      return cfg_limit_en;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step();
      int g;
      bit found;
      m_prev = (m_cur >= 0) ? m_cur : -2;
      if (m_cur == -2 && out_rdy) begin
         found = 0;
         g = 0;
         if (elig(m_ptr) && m_cred != 0) begin
            found = 1;
            g = m_ptr;
         end else begin
            for (int k = 1; k <= QN; k++) begin
               int q;
               q = (m_ptr + k) % QN;
               if (!found && elig(q)) begin
                  found = 1;
                  g = q;
                  m_cred = int'(cfg_wgt[q*WW +: WW]);
               end
            end
         end
         if (found) begin
            m_ptr = g;
            m_cred = m_cred - 1;
            for (int b = 0; b < CL; b++) m_plan.push_back(g*256 + b);
         end
      end
      if (m_cur >= 0 && (m_cur % 256) == CL-1 && limit_on())
         for (int i = 0; i < CG; i++) m_plan.push_back(-1);
      m_cur = (m_plan.size() == 0) ? -2 : m_plan.pop_front();
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_plan.delete();
            m_cur = -2; m_prev = -2; m_ptr = 0; m_cred = 0;
         end else begin
            model_step();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int log_cyc[$];
   int log_q[$];

   initial begin
      logic [QN-1:0] exp_ren;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_ren = '0;
            if (m_cur >= 0) exp_ren = QN'(1) << (m_cur / 256);
            check("que_ren", que_ren, exp_ren);
            check("cell_vld", cell_vld, m_prev >= 0);
            check("sched_busy", sched_busy, m_cur != -2);
            if (m_prev >= 0) begin
               check("cell_sop", cell_sop, (m_prev % 256) == 0);
               check("cell_eop", cell_eop, (m_prev % 256) == CL-1);
               check("cell_qid", cell_qid, m_prev / 256);
            end
            if (cell_vld && cell_sop) begin
               log_cyc.push_back(cyc);
               log_q.push_back(int'(cell_qid));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_cyc.delete();
      log_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic wait_sops(input int n, input int budget, input string name);
      int c;
      c = 0;
      while (log_q.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      check(name, log_q.size(), n);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int p3[8];
      int ren_cnt;
      int c;
      int r;
      p3 = '{1, 0, 0, 0, 1, 0, 0, 0};

      // T1: reset, nothing to send
      cfg_wgt = 32'h1111_1111; que_nempty = '0; out_rdy = 1'b1; cfg_limit_en = 1'b0;
      tick(1);
      do_reset();
      check("t1_reset_ren", que_ren, 0);
      check("t1_reset_vld", cell_vld, 0);
      tick(50);
      check("t1_no_cells", log_q.size(), 0);
      check("t1_idle_busy", sched_busy, 0);

      // T2: all queues full, all weights 1
      que_nempty = 8'hFF;
      wait_sops(8, 100, "t2_sop_count");
      for (int i = 0; i < log_q.size(); i++) check("t2_qid", log_q[i], (i + 1) % QN);
      for (int i = 1; i < log_q.size(); i++) check("t2_spacing", log_cyc[i] - log_cyc[i-1], CL + 1);
      out_rdy = 1'b0;
      tick(10);

      // T3: q0 weight 3, q1 weight 1
      cfg_wgt = 32'h0000_0013; que_nempty = 8'h03;
      do_reset();
      out_rdy = 1'b1;
      wait_sops(8, 100, "t3_sop_count");
      for (int i = 0; i < log_q.size(); i++) check("t3_qid", log_q[i], p3[i]);
      out_rdy = 1'b0;
      tick(10);

      // T4: out_rdy dropped on beat 1 of a q2 cell
      cfg_wgt = 32'h1111_1111; que_nempty = 8'h04;
      do_reset();
      out_rdy = 1'b1;
      c = 0;
      while (!que_ren[2] && c < 50) begin tick(1); c++; end
      check("t4_first_ren", que_ren, 8'h04);
      ren_cnt = 1;
      tick(1);
      out_rdy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (que_ren[2]) ren_cnt++;
         tick(1);
      end
      check("t4_full_cell_beats", ren_cnt, CL);
      check("t4_no_grant_held", log_q.size(), 1);
      check("t4_ren_held_low", que_ren, 0);
      out_rdy = 1'b1;
      r = cyc;
      wait_sops(2, 20, "t4_regrant");
      if (log_q.size() >= 2) begin
         check("t4_regrant_cycle", log_cyc[1], r + 2);
         check("t4_regrant_qid", log_q[1], 2);
      end
      out_rdy = 1'b0;
      tick(10);

      // T5: rate limit on, then off, single queue q3
      cfg_wgt = 32'h0000_2000; que_nempty = 8'h08; cfg_limit_en = 1'b1;
      do_reset();
      out_rdy = 1'b1;
      wait_sops(4, 200, "t5_lim_sop_count");
      for (int i = 1; i < log_q.size(); i++) check("t5_lim_spacing", log_cyc[i] - log_cyc[i-1], LIM_SPACING);
      cfg_limit_en = 1'b0;
      clear_log();
      wait_sops(4, 200, "t5_free_sop_count");
      for (int i = 2; i < log_q.size(); i++) check("t5_free_spacing", log_cyc[i] - log_cyc[i-1], CL + 1);
      out_rdy = 1'b0;
      tick(20);

      // T6: reset on beat 2 of a cell
      cfg_wgt = 32'h1111_1111; que_nempty = 8'hFF;
      do_reset();
      out_rdy = 1'b1;
      c = 0;
      while (que_ren == 0 && c < 50) begin tick(1); c++; end
      tick(2);
      check("t6_vld_before_rst", cell_vld, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_ren", que_ren, 0);
      check("t6_rst_vld", cell_vld, 0);
      check("t6_rst_sop", cell_sop, 0);
      check("t6_rst_busy", sched_busy, 0);
      que_nempty = 8'h11;
      tick(1);
      rst = 1'b0;
      clear_log();
      wait_sops(1, 30, "t6_after_rst_sop");
      if (log_q.size() >= 1) check("t6_after_rst_qid", log_q[0], 4);
      tick(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
